// File: rtl/fifo_drain_if.sv
// Handshake bundle between fifo_drain, the 8-deep FIFO read port and the downstream consumer.
// master = the drain engine, slave = the FIFO/consumer side.
interface fifo_drain_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 4
);
   logic                  start;
   logic [CNT_WIDTH-1:0]  burst_len;
   logic                  fifo_empty;
   logic                  fifo_rd_ack;
   logic                  fifo_rd_err;
   logic [DATA_WIDTH-1:0] fifo_dout;
   logic                  fifo_re;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [CNT_WIDTH-1:0]  words_left;

   modport master (
      input  start, burst_len, fifo_empty, fifo_rd_ack, fifo_rd_err, fifo_dout, out_ready,
      output fifo_re, out_data, out_valid, busy, done, err, words_left
   );

   modport slave (
      output start, burst_len, fifo_empty, fifo_rd_ack, fifo_rd_err, fifo_dout, out_ready,
      input  fifo_re, out_data, out_valid, busy, done, err, words_left
   );
endinterface

// File: rtl/fifo_drain.sv
// FIFO read-side burst engine: one fifo_re per word, ack/err one cycle later, word held on a valid/ready stream.
// Best case one word per 3 cycles; stalls in ISSUE while the FIFO is empty and in HOLD while out_ready is low.
module fifo_drain #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 4
) (
   input  logic         clk,
   input  logic         reset,
   fifo_drain_if.master bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'b000,
      ISSUE = 3'b001,
      WAIT  = 3'b010,
      HOLD  = 3'b011,
      DONE  = 3'b100,
      ERR   = 3'b101
   } state_t;

   state_t state;
   state_t state_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         bus.out_data   <= '0;
         bus.out_valid  <= 1'b0;
         bus.words_left <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  bus.words_left <= bus.burst_len;
               end
            end
            WAIT: begin
               // an ack coinciding with err is treated as an error, so no capture
               if (bus.fifo_rd_ack && !bus.fifo_rd_err) begin
                  bus.out_data   <= bus.fifo_dout;
                  bus.out_valid  <= 1'b1;
                  bus.words_left <= bus.words_left - CNT_WIDTH'(1);
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = (bus.burst_len != '0) ? ISSUE : DONE;
            end
         end
         ISSUE: begin
            if (!bus.fifo_empty) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            // a missing response is a protocol violation and aborts like an error
            if (bus.fifo_rd_ack && !bus.fifo_rd_err) begin
               state_nxt = HOLD;
            end else begin
               state_nxt = ERR;
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               state_nxt = (bus.words_left == '0) ? DONE : ISSUE;
            end
         end
         DONE:    state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.fifo_re = (state == ISSUE) && !bus.fifo_empty;
   assign bus.busy    = (state != IDLE);
   assign bus.done    = (state == DONE);
   assign bus.err     = (state == ERR);

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: behavioural FIFO responder plus an in-order expected-word queue,
// directed scenarios followed by randomized bursts with random backpressure and late data.
module tb_fifo_drain;
   localparam int DW = 32;
   localparam int CW = 4;

   logic clk;
   logic reset;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   fifo_drain_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

   fifo_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] fq[$];
   logic [DW-1:0] exp_q[$];
   int  re_cnt, done_cnt, err_cnt, delivered, pend;
   bit  inject_err, stall, rand_ready;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic clr_counts();
      re_cnt = 0; done_cnt = 0; err_cnt = 0; delivered = 0;
   endtask

   task automatic push(input logic [DW-1:0] d);
      fq.push_back(d);
      exp_q.push_back(d);
      bus.fifo_empty = stall;
   endtask

   task automatic flush();
      fq.delete();
      exp_q.delete();
      bus.fifo_empty = 1'b1;
   endtask

   // One clock: observe at the falling edge, then model the FIFO's registered response.
   task automatic step();
      logic re_s;
      @(negedge clk);
      re_s = bus.fifo_re;
      if (re_s) re_cnt++;
      if (bus.done) done_cnt++;
      if (bus.err) err_cnt++;
      if (bus.out_valid && bus.out_ready && !reset) begin
         delivered++;
         if (exp_q.size() == 0) chk("extra_word", bus.out_valid, 1'b0);
         else chk("word", bus.out_data, exp_q.pop_front());
      end
      @(posedge clk);
      #1;
      bus.fifo_rd_ack = 1'b0;
      bus.fifo_rd_err = 1'b0;
      if (re_s) begin
         if (inject_err || fq.size() == 0) begin
            bus.fifo_rd_err = 1'b1;
            inject_err = 1'b0;
         end else begin
            bus.fifo_rd_ack = 1'b1;
            bus.fifo_dout   = fq.pop_front();
         end
      end
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      if (pend > 0 && $urandom_range(0, 2) == 0) begin
         push($urandom);
         pend--;
      end
      bus.fifo_empty = (fq.size() == 0) || stall;
      #1;
   endtask

   task automatic run_idle(input int max);
      int n = 0;
      while (bus.busy && n < max) begin
         step();
         n++;
      end
      chk("idle_timeout_busy", bus.busy, 1'b0);
   endtask

   task automatic wait_valid(input int max);
      int n = 0;
      while (!bus.out_valid && n < max) begin
         step();
         n++;
      end
      chk("valid_timeout", bus.out_valid, 1'b1);
   endtask

   task automatic kick(input int len);
      bus.start     = 1'b1;
      bus.burst_len = CW'(len);
      step();
      bus.start     = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] held;
      reset = 1'b1;
      bus.start = 1'b0; bus.burst_len = '0; bus.fifo_empty = 1'b1;
      bus.fifo_rd_ack = 1'b0; bus.fifo_rd_err = 1'b0; bus.fifo_dout = '0; bus.out_ready = 1'b0;
      inject_err = 0; stall = 0; rand_ready = 0; pend = 0;
      clr_counts();
      repeat (3) step();
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_out_data", bus.out_data, '0);
      chk("rst_words_left", bus.words_left, '0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_err", bus.err, 1'b0);
      chk("rst_fifo_re", bus.fifo_re, 1'b0);
      reset = 1'b0;
      step();

      // happy path
      clr_counts();
      push(32'hA); push(32'hB); push(32'hC);
      bus.out_ready = 1'b1;
      kick(3);
      run_idle(60);
      chk("happy_re_pulses", re_cnt, 3);
      chk("happy_words", delivered, 3);
      chk("happy_done", done_cnt, 1);
      chk("happy_err", err_cnt, 0);
      chk("happy_words_left", bus.words_left, 0);

      // backpressure in HOLD
      clr_counts();
      push($urandom); push($urandom);
      bus.out_ready = 1'b0;
      kick(2);
      wait_valid(20);
      held = bus.out_data;
      chk("bp_first_word", held, exp_q[0]);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_valid_held", bus.out_valid, 1'b1);
         chk("bp_data_stable", bus.out_data, held);
         chk("bp_no_re", bus.fifo_re, 1'b0);
      end
      bus.out_ready = 1'b1;
      step();
      chk("bp_valid_drop", bus.out_valid, 1'b0);
      chk("bp_re_after", bus.fifo_re, 1'b1);
      run_idle(40);
      chk("bp_words", delivered, 2);
      chk("bp_done", done_cnt, 1);

      // empty stall in ISSUE
      clr_counts();
      kick(1);
      for (int i = 0; i < 4; i++) begin
         chk("stall_no_re", bus.fifo_re, 1'b0);
         chk("stall_busy", bus.busy, 1'b1);
         step();
      end
      push(32'h5A5A_0001);
      #1;
      chk("stall_re_release", bus.fifo_re, 1'b1);
      run_idle(40);
      chk("stall_words", delivered, 1);
      chk("stall_done", done_cnt, 1);

      // error abort after two delivered words
      clr_counts();
      for (int i = 0; i < 4; i++) push($urandom);
      kick(4);
      begin
         int n = 0;
         while (delivered < 2 && n < 60) begin
            step();
            n++;
         end
      end
      chk("err_pre_words", delivered, 2);
      inject_err = 1'b1;
      step();
      step();
      chk("err_pulse", bus.err, 1'b1);
      chk("err_out_valid", bus.out_valid, 1'b0);
      chk("err_no_done", bus.done, 1'b0);
      step();
      chk("err_count", err_cnt, 1);
      chk("err_done_count", done_cnt, 0);
      chk("err_idle", bus.busy, 1'b0);
      chk("err_words_left", bus.words_left, 2);
      step();
      chk("err_words_left_hold", bus.words_left, 2);
      flush();

      // zero-length burst
      clr_counts();
      kick(0);
      chk("zero_done", bus.done, 1'b1);
      chk("zero_no_re", bus.fifo_re, 1'b0);
      step();
      chk("zero_done_clear", bus.done, 1'b0);
      chk("zero_idle", bus.busy, 1'b0);
      chk("zero_re_count", re_cnt, 0);

      // start while busy is ignored
      clr_counts();
      push($urandom); push($urandom); push($urandom);
      bus.out_ready = 1'b0;
      kick(3);
      wait_valid(20);
      chk("busy_wl_before", bus.words_left, 2);
      kick(7);
      chk("busy_wl_after", bus.words_left, 2);
      chk("busy_valid_kept", bus.out_valid, 1'b1);
      bus.out_ready = 1'b1;
      run_idle(60);
      chk("busy_words", delivered, 3);
      chk("busy_re_count", re_cnt, 3);
      chk("busy_done", done_cnt, 1);

      // reset in HOLD drops the held word
      clr_counts();
      push($urandom); push($urandom);
      bus.out_ready = 1'b0;
      kick(2);
      wait_valid(20);
      reset = 1'b1;
      step();
      reset = 1'b0;
      void'(exp_q.pop_front());
      chk("mid_rst_valid", bus.out_valid, 1'b0);
      chk("mid_rst_busy", bus.busy, 1'b0);
      chk("mid_rst_words_left", bus.words_left, 0);
      chk("mid_rst_data", bus.out_data, 0);
      step();
      chk("mid_rst_no_done", done_cnt, 0);
      chk("mid_rst_no_err", err_cnt, 0);
      bus.out_ready = 1'b1;
      kick(1);
      run_idle(40);
      chk("post_rst_words", delivered, 1);
      chk("post_rst_done", done_cnt, 1);
      chk("post_rst_fifo_drained", exp_q.size(), 0);

      // randomized bursts: data trickles in, consumer randomly stalls
      for (int b = 0; b < 15; b++) begin
         int len;
         clr_counts();
         len = $urandom_range(1, 8);
         pend = len;
         rand_ready = 1'b1;
         kick(len);
         run_idle(400);
         rand_ready = 1'b0;
         chk("rnd_words", delivered, len);
         chk("rnd_re_count", re_cnt, len);
         chk("rnd_done", done_cnt, 1);
         chk("rnd_err", err_cnt, 0);
         chk("rnd_words_left", bus.words_left, 0);
         chk("rnd_exp_empty", exp_q.size(), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
